// File: rtl/serial_magnitude_comparator_if.sv
// Digit-input and frame-result handshakes of the serial magnitude comparator.
// The master side feeds digit pairs and accepts results; the slave side is the comparator.
interface serial_magnitude_comparator_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] A;
  logic [1:0] B;
  logic       res_valid;
  logic       res_ready;
  logic       res_eq;
  logic       res_gt;
  logic       res_lt;

  modport master (
    output in_valid, A, B, res_ready,
    input  in_ready, res_valid, res_eq, res_gt, res_lt
  );

  modport slave (
    input  in_valid, A, B, res_ready,
    output in_ready, res_valid, res_eq, res_gt, res_lt
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Compares two DIGITS-digit base-4 words fed MSB-first, one digit pair per beat, and
// reports eq/gt/lt per frame; also counts equal frames, saturating.
module serial_magnitude_comparator #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_magnitude_comparator_if.slave bus,
  output logic [CNT_W-1:0]            eq_count
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] dig_cnt;
  logic             decided;
  logic             gt_flag;
  logic             decided_nxt;
  logic             gt_nxt;

  // The first differing digit (MSB-first) fixes the outcome; later digits cannot change it.
  always_comb begin
    decided_nxt = decided;
    gt_nxt      = gt_flag;
    if (!decided && (bus.A != bus.B)) begin
      decided_nxt = 1'b1;
      gt_nxt      = (bus.A > bus.B);
    end
  end

  assign bus.in_ready = (state == ACCUM) && !rst;

  // NOTE: every register here is updated with <= so all state moves together on the edge,
  // and the asynchronous reset sits in the sensitivity list so it acts without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      dig_cnt       <= '0;
      decided       <= 1'b0;
      gt_flag       <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_eq    <= 1'b0;
      bus.res_gt    <= 1'b0;
      bus.res_lt    <= 1'b0;
      eq_count      <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            decided <= decided_nxt;
            gt_flag <= gt_nxt;
            if (dig_cnt == LAST_IDX) begin
              state         <= HOLD;
              bus.res_valid <= 1'b1;
              bus.res_eq    <= !decided_nxt;
              bus.res_gt    <= decided_nxt && gt_nxt;
              bus.res_lt    <= decided_nxt && !gt_nxt;
              if (!decided_nxt && (eq_count != CNT_MAX)) eq_count <= eq_count + 1'b1;
            end else begin
              dig_cnt <= dig_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            state         <= ACCUM;
            dig_cnt       <= '0;
            decided       <= 1'b0;
            gt_flag       <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_eq    <= 1'b0;
            bus.res_gt    <= 1'b0;
            bus.res_lt    <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Downstream consumer of the 2-bit equality-compare stage.
- Accepts a multi-digit operand pair serially, one 2-bit digit of A and B per accepted beat, most-significant digit first.
- After DIGITS beats, reports A==B, A>B or A<B for the whole word through a valid/ready result handshake.
- Keeps a saturating count of frames that compared equal.

Parameters:
- DIGITS, 4, number of 2-bit digits per frame; legal range 1..256.
- CNT_W, 8, width of the equal-frame counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  A/B digit pair valid this cycle
- in_ready  output  1  block can accept a digit this cycle
- A  input  2  current digit of operand A (MSB-first order)
- B  input  2  current digit of operand B (MSB-first order)
- res_valid  output  1  frame result available
- res_ready  input  1  downstream accepts result
- res_eq  output  1  frame A==B
- res_gt  output  1  frame A>B
- res_lt  output  1  frame A<B
- eq_count  output  CNT_W  number of equal frames, saturating

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - While rst=1: state=ACCUM, digit counter=0, decided=0, gt_flag=0, res_valid=0, res_eq=0, res_gt=0, res_lt=0, eq_count=0.
  - in_ready=0 while rst=1.
- Accept: a digit is accepted on a rising clk edge with in_valid=1 and in_ready=1. in_ready = (state==ACCUM) and not rst, derived combinationally from the state register.
- State ACCUM:
  - Per accepted digit: if decided=0 and A!=B, set decided=1 and gt_flag=(A>B), unsigned 2-bit compare. If decided=1, later digits are ignored for the result.
  - The digit counter increments per accepted digit. When the counter equals DIGITS-1, the next accepted digit ends the frame: go to HOLD.
  - in_valid=0 cycles are bubbles: no state change, counter held.
- Entering HOLD (same edge as the last digit, including that digit's contribution):
  - res_valid=1.
  - res_eq = not decided_final, res_gt = decided_final and gt_flag_final, res_lt = decided_final and not gt_flag_final. Exactly one of the three is 1.
  - If res_eq, eq_count increments, saturating at 2^CNT_W-1. It holds at max thereafter.
- Latency: result registered and visible in the cycle after the last digit is accepted.
- State HOLD:
  - in_ready=0; in_valid and A/B are ignored.
  - res_eq/gt/lt and res_valid are stable until res_valid and res_ready are both 1 on an edge.
  - On that edge: res_valid=0, res flags cleared to 0, counter=0, decided=0, gt_flag=0, state=ACCUM.
  - The next digit can be accepted the following cycle. No result/input overlap; one result in flight max.
- res_ready while res_valid=0: ignored.
- DIGITS=1: every accepted digit produces a result.
- Reset mid-frame or mid-HOLD: partial frame discarded, pending result dropped, eq_count cleared.
- eq_count is never cleared except by reset.

Test Plan:
- DIGITS=4, res_ready=1:
  - Frame A=2,1,3,0 / B=2,1,3,0, back-to-back → res_valid one cycle after the 4th digit, res_eq=1, eq_count=1. in_ready=0 for exactly one cycle.
  - Frame A=1,3,0,0 / B=1,2,3,3 → res_gt=1 (decided at digit 2; later digits ignored). eq_count unchanged.
  - Frame A=0,0,0,1 / B=0,0,0,2 → res_lt=1 after the last digit only.
- Back-pressure: res_ready=0 for 5 cycles after a result while in_valid=1 with changing A/B → in_ready=0 throughout, result flags stable, no digit consumed. res_ready=1 → next frame starts cleanly.
- Bubbles: 2-cycle in_valid=0 gaps between each digit of an equal frame → same result as back-to-back, res_eq=1.
- Saturation: CNT_W=2, five consecutive equal frames → eq_count 1,2,3,3,3.
- Reset mid-frame: rst pulse after 2 digits (A=3 vs B=0 already seen), then full frame A=B → res_eq=1, eq_count=1. No stale gt.
